gap_stream_q8: RTL and testbench

Global-average-pooling stage that sits directly upstream of the dense/logits layer. It consumes the final conv feature map as a channel-interleaved stream of signed 8-bit activations. It accumulates one sum per channel over all pixels and emits a CHANNELS-long vector of rounded channel means as a second stream. The output is sign-extended to the 25-bit GAP word width used by the dense stage.

---
 rtl/gap_stream_q8.sv | 102 ++++++++++
 tb/tb_gap_stream_q8.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gap_stream_q8.sv
// Global-average-pooling stage: sums a channel-interleaved activation stream per channel
// over one frame, then drains the rounded per-channel means as a sign-extended word stream.
module gap_stream_q8 #(
  parameter int CHANNELS    = 64,
  parameter int LOG2_PIXELS = 6,
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 25,
  parameter int ACC_W       = DATA_W + LOG2_PIXELS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [ACC_W:0]  RND     = (ACC_W + 1)'(2 ** (LOG2_PIXELS - 1));

  logic [0:0]             r_state;
  logic [CH_W-1:0]        r_ch_cnt;
  logic [CH_W-1:0]        r_out_idx;
  logic [LOG2_PIXELS-1:0] r_px_cnt;
  logic [ACC_W-1:0]       r_acc [CHANNELS];

  logic             w_in_hs, w_out_hs, w_frame_end;
  logic [ACC_W-1:0] w_in_ext, w_sel;
  logic [ACC_W:0]   w_ext, w_mag, w_q, w_rnd;
  logic             w_neg;

  assign in_ready    = (r_state == S_ACCUM);
  assign out_valid   = (r_state == S_DRAIN);
  assign w_in_hs     = in_valid & in_ready;
  assign w_out_hs    = out_valid & out_ready;
  assign w_frame_end = (r_ch_cnt == CH_LAST) && (r_px_cnt == '1);
  assign w_in_ext    = {{LOG2_PIXELS{in_data[DATA_W-1]}}, in_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_ACCUM;
      r_ch_cnt  <= '0;
      r_px_cnt  <= '0;
      r_out_idx <= '0;
    end else begin
      case (r_state)
        S_ACCUM: if (w_in_hs) begin
          if (r_ch_cnt == CH_LAST) begin
            r_ch_cnt <= '0;
            r_px_cnt <= r_px_cnt + 1'b1;
            if (w_frame_end) begin
              r_state   <= S_DRAIN;
              r_out_idx <= '0;
            end
          end else begin
            r_ch_cnt <= r_ch_cnt + 1'b1;
          end
        end
        default: if (w_out_hs) begin
          if (r_out_idx == CH_LAST) begin
            r_state   <= S_ACCUM;
            r_out_idx <= '0;
          end else begin
            r_out_idx <= r_out_idx + 1'b1;
          end
        end
      endcase
    end
  end

  // Draining clears each sum as it leaves, so the next frame starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_in_hs && r_ch_cnt == CH_W'(i))
          r_acc[i] <= r_acc[i] + w_in_ext;
        else if (w_out_hs && r_out_idx == CH_W'(i))
          r_acc[i] <= '0;
      end
    end
  end

  // Round half away from zero on the magnitude; one extra bit keeps -min representable.
  assign w_sel = r_acc[r_out_idx];
  assign w_ext = {w_sel[ACC_W-1], w_sel};
  assign w_neg = w_ext[ACC_W];
  assign w_mag = w_neg ? (~w_ext + 1'b1) : w_ext;
  assign w_q   = (w_mag + RND) >> LOG2_PIXELS;
  assign w_rnd = w_neg ? (~w_q + 1'b1) : w_q;

  assign out_data = out_valid ? {{(OUT_W - ACC_W - 1){w_rnd[ACC_W]}}, w_rnd} : '0;
  assign out_last = out_valid && (r_out_idx == CH_LAST);

endmodule

// File: tb/tb_gap_stream_q8.sv
// Randomized scoreboard bench for gap_stream_q8: a per-frame arithmetic model predicts the
// 64 channel means; an independent monitor checks every output handshake and stall.
module tb_gap_stream_q8;
  localparam int CH = 64, LP = 6, PX = 64, DW = 8, OW = 25;

  logic          clk = 1'b0, rst = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b0, out_last;
  logic [OW-1:0] out_data;

  gap_stream_q8 #(.CHANNELS(CH), .LOG2_PIXELS(LP), .DATA_W(DW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [OW-1:0] d; logic l; } exp_t;
  exp_t q[$];
  int   checks = 0, passed = 0, n_out = 0;
  int   or_mode = 0;
  bit   idle_en = 1'b0;
  int   frame [PX][CH];

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  function automatic int rnd_mean(input int s);
    if (s >= 0) return (s + PX / 2) / PX;
    return -((-s + PX / 2) / PX);
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      int s = 0;
      for (int p = 0; p < PX; p++) s += frame[p][c];
      e.d = OW'(rnd_mean(s));
      e.l = (c == CH - 1);
      q.push_back(e);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    int t = 0;
    bit ok;
    if (idle_en && $urandom_range(7) == 0) begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    do begin
      ok = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!ok && t < 2000);
    if (!ok) begin
      checks++;
      $display("FAIL in_accept_timeout: got no handshake want handshake within 2000 cycles");
    end
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) push_word(DW'(frame[i / CH][i % CH]));
  endtask

  task automatic run_frame();
    push_expected();
    send_words(CH * PX);
    chk("latency_out_valid", OW'(out_valid), OW'(1));
    chk("latency_in_ready", OW'(in_ready), OW'(0));
  endtask

  task automatic drain_wait();
    int t = 0;
    in_valid = 1'b0;
    while (q.size() > 0 && t < 3000) begin @(posedge clk); #1; t++; end
    chk("drain_complete_left", OW'(q.size()), OW'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string nm);
    #2 rst = 1'b0;
    #1;
    chk({nm, "_out_valid"}, OW'(out_valid), OW'(0));
    chk({nm, "_out_last"}, OW'(out_last), OW'(0));
    chk({nm, "_out_data"}, out_data, OW'(0));
    chk({nm, "_in_ready"}, OW'(in_ready), OW'(1));
    q.delete();
    in_valid = 1'b0;
    #10 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic fill_const(input int v);
    for (int p = 0; p < PX; p++) for (int c = 0; c < CH; c++) frame[p][c] = v;
  endtask

  task automatic fill_rand();
    for (int p = 0; p < PX; p++)
      for (int c = 0; c < CH; c++) frame[p][c] = int'($urandom_range(255)) - 128;
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = $urandom_range(1) == 1;
        default: out_ready = (k % 4 == 0) || (k % 4 == 3);
      endcase
      k++;
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks stall stability.
  initial begin
    bit            prev_stall = 1'b0, after_last = 1'b0;
    logic [OW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
        after_last = 1'b0;
      end else begin
        if (after_last) begin
          chk("in_ready_after_last", OW'(in_ready), OW'(1));
          chk("out_valid_after_last", OW'(out_valid), OW'(0));
          after_last = 1'b0;
        end
        chk("state_exclusive", OW'(in_ready), OW'(!out_valid));
        if (out_valid && prev_stall) begin
          chk("stall_hold_data", out_data, prev_d);
          chk("stall_hold_last", OW'(out_last), OW'(prev_l));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: got %h want no output", out_data);
          end else begin
            e = q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", OW'(out_last), OW'(e.l));
          end
          if (out_last) after_last = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_l     = out_last;
      end
    end
  end

  initial begin
    #3;
    chk("reset_out_valid", OW'(out_valid), OW'(0));
    chk("reset_out_last", OW'(out_last), OW'(0));
    chk("reset_out_data", out_data, OW'(0));
    chk("reset_in_ready", OW'(in_ready), OW'(1));
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // constant 1
    or_mode = 0; idle_en = 1'b0;
    fill_const(1);
    run_frame(); drain_wait();

    // per-channel ramp c-32, random idle cycles, random out_ready
    or_mode = 1; idle_en = 1'b1;
    for (int p = 0; p < PX; p++) for (int c = 0; c < CH; c++) frame[p][c] = c - 32;
    run_frame(); drain_wait();

    // rounding boundaries, out_ready pattern 1-0-0-1
    or_mode = 2; idle_en = 1'b0;
    fill_rand();
    for (int p = 0; p < PX; p++) begin
      frame[p][0] = (p == 0) ? 32 : 0;
      frame[p][1] = (p == 0) ? 31 : 0;
      frame[p][2] = (p == 0) ? -32 : 0;
      frame[p][3] = (p == 0) ? -31 : 0;
      frame[p][4] = -128;
      frame[p][5] = 127;
    end
    run_frame();
    in_valid = 1'b1;   // held high through the drain; must be ignored
    in_data  = 8'h7f;
    repeat (20) begin @(posedge clk); #1; end
    drain_wait();

    // back-to-back: all 5 then all -3, next frame waits with in_valid high during drain
    or_mode = 0; idle_en = 1'b0;
    fill_const(5);  run_frame();
    fill_const(-3); run_frame();
    drain_wait();

    // random frames with random flow control
    or_mode = 1; idle_en = 1'b1;
    repeat (2) begin fill_rand(); run_frame(); drain_wait(); end

    // reset mid-frame after 1000 words, then mid-drain after 10 outputs
    or_mode = 0; idle_en = 1'b0;
    fill_const(9);
    send_words(1000);
    do_reset("rst_midframe");
    begin
      int base, t;
      fill_const(3);
      run_frame();
      base = n_out; t = 0;
      while (n_out < base + 10 && t < 200) begin @(posedge clk); #1; t++; end
      chk("middrain_outputs_seen", OW'(n_out >= base + 10), OW'(1));
      do_reset("rst_middrain");
    end
    fill_const(7);
    run_frame(); drain_wait();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
